// File: rtl/multicycle_add_sub_if.sv
// Operand/result bundle for the multi-cycle adder/subtractor.
// master drives the request side, slave (the datapath) drives status and results.
interface multicycle_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SnA;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] Y;
  logic             CO;
  logic             OVF;
  logic             ZERO;

  modport master (
    output START, A, B, SnA,
    input  BUSY, DONE, Y, CO, OVF, ZERO
  );

  modport slave (
    input  START, A, B, SnA,
    output BUSY, DONE, Y, CO, OVF, ZERO
  );
endinterface

// File: rtl/multicycle_add_sub.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered carry between slices.
// Latency NCHUNK cycles from the accepting START edge; START is ignored while BUSY.
module multicycle_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                CLK,
  input logic                RST,
  multicycle_add_sub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, stateNext;
  logic [IDXW-1:0]  idx, idxNext;
  logic             carry, carryNext;
  logic [WIDTH-1:0] aReg, aNext, bReg, bNext, acc, accNext, yReg, yNext;
  logic             coReg, coNext, ovfReg, ovfNext, zeroReg, zeroNext, doneReg, doneNext;

  logic [CHUNK-1:0] aSlice, bSlice;
  logic [CHUNK:0]   sliceSum;
  logic             msbCin;

  always_comb begin
    aSlice   = aReg[idx*CHUNK +: CHUNK];
    bSlice   = bReg[idx*CHUNK +: CHUNK];
    sliceSum = {1'b0, aSlice} + {1'b0, bSlice} + {{CHUNK{1'b0}}, carry};
    // Carry into the slice MSB recovered from the sum bit; on the last slice this is cin(MSB).
    msbCin   = aSlice[CHUNK-1] ^ bSlice[CHUNK-1] ^ sliceSum[CHUNK-1];
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    carryNext = carry;
    aNext     = aReg;
    bNext     = bReg;
    accNext   = acc;
    yNext     = yReg;
    coNext    = coReg;
    ovfNext   = ovfReg;
    zeroNext  = zeroReg;
    doneNext  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.START) begin
          aNext     = bus.A;
          bNext     = bus.SnA ? ~bus.B : bus.B;
          carryNext = bus.SnA;
          idxNext   = '0;
          stateNext = RUN;
        end
      end
      RUN: begin
        accNext[idx*CHUNK +: CHUNK] = sliceSum[CHUNK-1:0];
        carryNext = sliceSum[CHUNK];
        idxNext   = idx + IDXW'(1);
        if (idx == LAST) begin
          yNext     = accNext;
          coNext    = sliceSum[CHUNK];
          ovfNext   = msbCin ^ sliceSum[CHUNK];
          zeroNext  = (accNext == '0);
          doneNext  = 1'b1;
          idxNext   = '0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      aReg    <= '0;
      bReg    <= '0;
      acc     <= '0;
      yReg    <= '0;
      coReg   <= 1'b0;
      ovfReg  <= 1'b0;
      zeroReg <= 1'b1;
      doneReg <= 1'b0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      carry   <= carryNext;
      aReg    <= aNext;
      bReg    <= bNext;
      acc     <= accNext;
      yReg    <= yNext;
      coReg   <= coNext;
      ovfReg  <= ovfNext;
      zeroReg <= zeroNext;
      doneReg <= doneNext;
    end
  end

  assign bus.BUSY = (state == RUN);
  assign bus.DONE = doneReg;
  assign bus.Y    = yReg;
  assign bus.CO   = coReg;
  assign bus.OVF  = ovfReg;
  assign bus.ZERO = zeroReg;
endmodule
